// File: rtl/gpr_regfile_if.sv
// Bundle of write-back, decode-read and commit-trace signals for gpr_regfile.
// Trace signals exist only when REGFILE_TRACE_EN is defined.
interface gpr_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // There is no handshake on this bus: a write commits on every posedge
  // where we=1, and the read data is a pure combinational function of the
  // current cycle's inputs. Stall is handled upstream by freezing wb_*.
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [31:0]       wb_pc;

  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

`ifdef REGFILE_TRACE_EN
  logic              trace_valid;
  logic [31:0]       trace_pc;
  logic [3:0]        trace_wen;
  logic [ADDR_W-1:0] trace_wnum;
  logic [DATA_W-1:0] trace_wdata;

  modport master (
    output we, waddr, wdata, wb_pc,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2,
    input  trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata
  );

  modport slave (
    input  we, waddr, wdata, wb_pc,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2,
    output trace_valid, trace_pc, trace_wen, trace_wnum, trace_wdata
  );
`else
  modport master (
    output we, waddr, wdata, wb_pc,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, wb_pc,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
`endif
endinterface

// File: rtl/gpr_regfile.sv
// MIPS 32x32 GPR file with two bypassed decode read ports and $0 tied to zero.
// Define REGFILE_TRACE_EN to add the registered commit-trace port.
module gpr_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  gpr_regfile_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic              wr_en_d;

  // A write counts only outside reset and never targets $0.
  always_comb begin
    wr_en_d = 1'b0;
    if (!rst && bus.we && (bus.waddr != '0)) begin
      wr_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      mem_q[bus.waddr] <= bus.wdata;
    end
  end

  // Priority: reset, disabled port, $0, same-cycle bypass, storage.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_v,
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] r;
    r = '0;
    if (rst_v) begin
      r = '0;
    end else if (!re) begin
      r = '0;
    end else if (raddr == '0) begin
      r = '0;
    end else if (we && (waddr == raddr)) begin
      r = wdata;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  logic [DATA_W-1:0] rdata1_d;
  logic [DATA_W-1:0] rdata2_d;

  always_comb begin
    rdata1_d = read_port(rst, bus.re1, bus.raddr1, bus.we, bus.waddr,
                         bus.wdata, mem_q[bus.raddr1]);
    rdata2_d = read_port(rst, bus.re2, bus.raddr2, bus.we, bus.waddr,
                         bus.wdata, mem_q[bus.raddr2]);
  end

  assign bus.rdata1 = rdata1_d;
  assign bus.rdata2 = rdata2_d;

`ifdef REGFILE_TRACE_EN
  logic              trace_valid_q, trace_valid_d;
  logic [31:0]       trace_pc_q,    trace_pc_d;
  logic [3:0]        trace_wen_q,   trace_wen_d;
  logic [ADDR_W-1:0] trace_wnum_q,  trace_wnum_d;
  logic [DATA_W-1:0] trace_wdata_q, trace_wdata_d;

  // Payload fields hold between commits; only valid and the byte mask drop.
  always_comb begin
    trace_valid_d = wr_en_d;
    trace_pc_d    = trace_pc_q;
    trace_wen_d   = 4'h0;
    trace_wnum_d  = trace_wnum_q;
    trace_wdata_d = trace_wdata_q;
    if (wr_en_d) begin
      trace_pc_d    = bus.wb_pc;
      trace_wen_d   = 4'hF;
      trace_wnum_d  = bus.waddr;
      trace_wdata_d = bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_wen_q   <= '0;
      trace_wnum_q  <= '0;
      trace_wdata_q <= '0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_wen_q   <= trace_wen_d;
      trace_wnum_q  <= trace_wnum_d;
      trace_wdata_q <= trace_wdata_d;
    end
  end

  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_pc    = trace_pc_q;
  assign bus.trace_wen   = trace_wen_q;
  assign bus.trace_wnum  = trace_wnum_q;
  assign bus.trace_wdata = trace_wdata_q;
`else
  // The write-back PC only feeds the trace; fold it away in this build.
  logic unused_wb_pc;
  assign unused_wb_pc = ^bus.wb_pc;
`endif
endmodule

// File: tb/tb_gpr_regfile.sv
// Self-checking bench for gpr_regfile: directed scenarios plus random traffic
// checked every cycle against an array-based model of the register file.
module tb_gpr_regfile;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpr_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  gpr_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] model_mem [NREG];
  logic              exp_tv;
  logic [31:0]       exp_tpc;
  logic [3:0]        exp_twen;
  logic [ADDR_W-1:0] exp_twnum;
  logic [DATA_W-1:0] exp_twdata;

  // Architectural state after each edge: reset wipes everything, a write to
  // a nonzero index lands, and the trace records the commit one cycle late.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) model_mem[i] = '0;
      exp_tv = 0; exp_tpc = '0; exp_twen = '0; exp_twnum = '0; exp_twdata = '0;
    end else if (bus.we && bus.waddr != 0) begin
      model_mem[bus.waddr] = bus.wdata;
      exp_tv = 1; exp_tpc = bus.wb_pc; exp_twen = 4'hF;
      exp_twnum = bus.waddr; exp_twdata = bus.wdata;
    end else begin
      exp_tv = 0; exp_twen = 4'h0;
    end
  end

  function automatic logic [DATA_W-1:0] model_read(logic re, logic [ADDR_W-1:0] ra);
    if (rst || !re || ra == 0) return '0;
    if (bus.we && bus.waddr == ra) return bus.wdata;
    return model_mem[ra];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("rdata1", bus.rdata1, model_read(bus.re1, bus.raddr1));
      chk("rdata2", bus.rdata2, model_read(bus.re2, bus.raddr2));
`ifdef REGFILE_TRACE_EN
      chk("trace_valid", {31'b0, bus.trace_valid}, {31'b0, exp_tv});
      chk("trace_wen",   {28'b0, bus.trace_wen},   {28'b0, exp_twen});
      if (exp_tv) begin
        chk("trace_pc",    bus.trace_pc,             exp_tpc);
        chk("trace_wnum",  {27'b0, bus.trace_wnum},  {27'b0, exp_twnum});
        chk("trace_wdata", bus.trace_wdata,          exp_twdata);
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.we = 0; bus.waddr = '0; bus.wdata = '0; bus.wb_pc = '0;
    bus.re1 = 0; bus.raddr1 = '0; bus.re2 = 0; bus.raddr2 = '0;
  endtask

  // Move to just after the next active edge, where inputs may change.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let inputs settle; outputs are then sampled on the falling edge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [31:0] pc);
    next_cycle();
    set_idle();
    bus.we = 1; bus.waddr = a; bus.wdata = d; bus.wb_pc = pc;
    settle();
  endtask

  task automatic do_read(input logic r1, input logic [ADDR_W-1:0] a1,
                         input logic r2, input logic [ADDR_W-1:0] a2);
    next_cycle();
    set_idle();
    bus.re1 = r1; bus.raddr1 = a1; bus.re2 = r2; bus.raddr2 = a2;
    settle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1;
    settle();
    chk("rdata1_in_rst", bus.rdata1, 32'h0);

    // Reset state: every index reads zero on both ports.
    next_cycle();
    rst = 0;
    for (int i = 0; i < NREG; i++) begin
      do_read(1, ADDR_W'(i), 1, ADDR_W'(NREG - 1 - i));
      chk("reset_r1", bus.rdata1, 32'h0);
      chk("reset_r2", bus.rdata2, 32'h0);
`ifdef REGFILE_TRACE_EN
      chk("reset_tv", {31'b0, bus.trace_valid}, 32'h0);
`endif
    end

    // Write then read through storage, and a disabled port.
    do_write(5, 32'hDEADBEEF, 32'hBFC00000);
    do_read(1, 5, 0, 5);
    chk("wr_rd_r5", bus.rdata1, 32'hDEADBEEF);
    chk("re2_off", bus.rdata2, 32'h0);
    do_read(0, 5, 1, 5);
    chk("re1_off", bus.rdata1, 32'h0);
    chk("wr_rd_r5_p2", bus.rdata2, 32'hDEADBEEF);

    // $0 ignores writes, even in the write cycle itself.
    next_cycle();
    set_idle();
    bus.we = 1; bus.waddr = 0; bus.wdata = 32'hFFFFFFFF;
    bus.re1 = 1; bus.re2 = 1;
    settle();
    chk("zero_same_r1", bus.rdata1, 32'h0);
    chk("zero_same_r2", bus.rdata2, 32'h0);
    do_read(1, 0, 1, 0);
    chk("zero_next_r1", bus.rdata1, 32'h0);
`ifdef REGFILE_TRACE_EN
    chk("zero_no_trace", {31'b0, bus.trace_valid}, 32'h0);
`endif

    // Bypass: both ports see the in-flight write, then storage holds it.
    do_write(7, 32'h1, 32'h0);
    next_cycle();
    set_idle();
    bus.we = 1; bus.waddr = 7; bus.wdata = 32'h2;
    bus.re1 = 1; bus.raddr1 = 7; bus.re2 = 1; bus.raddr2 = 7;
    settle();
    chk("bypass_r1", bus.rdata1, 32'h2);
    chk("bypass_r2", bus.rdata2, 32'h2);
    do_read(1, 7, 1, 7);
    chk("after_bypass_r1", bus.rdata1, 32'h2);
    chk("after_bypass_r2", bus.rdata2, 32'h2);

    // Reset mid-write discards the write and forces zero reads.
    do_write(3, 32'h5, 32'h0);
    next_cycle();
    set_idle();
    rst = 1;
    bus.we = 1; bus.waddr = 3; bus.wdata = 32'h9;
    bus.re1 = 1; bus.raddr1 = 3; bus.re2 = 1; bus.raddr2 = 5;
    settle();
    chk("rst_write_r1", bus.rdata1, 32'h0);
    chk("rst_write_r2", bus.rdata2, 32'h0);
    next_cycle();
    rst = 0;
    set_idle();
    settle();
    do_read(1, 3, 1, 5);
    chk("after_rst_r3", bus.rdata1, 32'h0);
    chk("after_rst_r5", bus.rdata2, 32'h0);

    // Commit trace for a write to r31.
    do_write(31, 32'h80000008, 32'hBFC00010);
    do_read(1, 31, 0, 0);
    chk("r31", bus.rdata1, 32'h80000008);
`ifdef REGFILE_TRACE_EN
    chk("tr_valid", {31'b0, bus.trace_valid}, 32'h1);
    chk("tr_wen",   {28'b0, bus.trace_wen},   32'hF);
    chk("tr_wnum",  {27'b0, bus.trace_wnum},  32'd31);
    chk("tr_pc",    bus.trace_pc,             32'hBFC00010);
    chk("tr_wdata", bus.trace_wdata,          32'h80000008);
    do_read(0, 0, 0, 0);
    chk("tr_idle_valid", {31'b0, bus.trace_valid}, 32'h0);
    chk("tr_idle_wen",   {28'b0, bus.trace_wen},   32'h0);
`endif

    // Random traffic with addresses biased to a small window for collisions.
    for (int n = 0; n < 600; n++) begin
      next_cycle();
      rst        = ($urandom_range(0, 49) == 0);
      bus.we     = $urandom_range(0, 1);
      bus.waddr  = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 3))
                                               : ADDR_W'($urandom_range(0, NREG - 1));
      bus.wdata  = $urandom;
      bus.wb_pc  = $urandom;
      bus.re1    = ($urandom_range(0, 3) != 0);
      bus.raddr1 = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 3))
                                               : ADDR_W'($urandom_range(0, NREG - 1));
      bus.re2    = ($urandom_range(0, 3) != 0);
      bus.raddr2 = ($urandom_range(0, 2) == 0) ? bus.raddr1
                                               : ADDR_W'($urandom_range(0, 3));
      settle();
    end

    next_cycle();
    rst = 0;
    set_idle();
    settle();
    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
